sync_fifo_prog: RTL and testbench

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 106 ++++++++++
 tb/tb_sync_fifo_prog.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO of any depth with programmable almost-full/almost-empty flags and registered status pulses.
// Optional saturating overflow/underflow event counters are enabled with the SYNC_FIFO_ERR_CNT_EN macro.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [FIFO_WIDTH-1:0]              data_in,
    input  logic                               rd_en,
    output logic [FIFO_WIDTH-1:0]              data_out,
    output logic                               full,
    output logic                               empty,
    output logic                               almostfull,
    output logic                               almostempty,
    output logic                               wr_ack,
    output logic                               overflow,
    output logic                               underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
`ifdef SYNC_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]                         ovf_cnt,
    output logic [7:0]                         udf_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_reject;
    logic                  rd_reject;

    // Handshake: a request is taken on the rising edge where it is accepted; a write
    // is accepted when not full or when a read leaves room the same cycle, a read
    // when not empty; rejected requests are dropped and reported by a one-cycle pulse.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_en);
    assign wr_reject = wr_en && !wr_accept;
    assign rd_reject = rd_en && !rd_accept;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CW'(AF_THRESH));
    assign almostempty = (count != '0) && (count <= CW'(AE_THRESH));

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_reject;
            underflow <= rd_reject;
            if (wr_accept) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (wr_reject && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (rd_reject && udf_cnt != 8'hFF) begin
                udf_cnt <= udf_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed scenarios plus random traffic against a queue-based reference model.
// Define SYNC_FIFO_ERR_CNT_EN for both bench and RTL to also check the saturating error counters.
module tb_sync_fifo_prog;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = D - 1;
    localparam int AE = 1;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          full, empty, almostfull, almostempty;
    logic          wr_ack, overflow, underflow;
    logic [CW-1:0] count;
`ifdef SYNC_FIFO_ERR_CNT_EN
    logic [7:0]    ovf_cnt, udf_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout;
    logic         exp_ack, exp_ovf, exp_udf;
    int           exp_ovf_cnt, exp_udf_cnt;

    sync_fifo_prog #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almostfull(almostfull), .almostempty(almostempty),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .count(count)
`ifdef SYNC_FIFO_ERR_CNT_EN
        , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model, check #1 after the rising edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] din);
        logic rd_ok, wr_ok;
        int n;
        @(negedge clk);
        rst = r; wr_en = w; rd_en = rd; data_in = din;
        if (r) begin
            exp_q.delete();
            exp_dout = '0; exp_ack = 0; exp_ovf = 0; exp_udf = 0;
            exp_ovf_cnt = 0; exp_udf_cnt = 0;
        end else begin
            n     = exp_q.size();
            rd_ok = rd && (n > 0);
            wr_ok = w && ((n < D) || rd);
            if (rd_ok) exp_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(din);
            exp_ack = wr_ok;
            exp_ovf = w && !wr_ok;
            exp_udf = rd && !rd_ok;
            if (exp_ovf && exp_ovf_cnt < 255) exp_ovf_cnt++;
            if (exp_udf && exp_udf_cnt < 255) exp_udf_cnt++;
        end
        @(posedge clk);
        #1;
        n = exp_q.size();
        check("data_out",    32'(data_out),    32'(exp_dout));
        check("count",       32'(count),       32'(n));
        check("full",        32'(full),        32'(n == D));
        check("empty",       32'(empty),       32'(n == 0));
        check("almostfull",  32'(almostfull),  32'(n >= AF));
        check("almostempty", 32'(almostempty), 32'((n != 0) && (n <= AE)));
        check("wr_ack",      32'(wr_ack),      32'(exp_ack));
        check("overflow",    32'(overflow),    32'(exp_ovf));
        check("underflow",   32'(underflow),   32'(exp_udf));
`ifdef SYNC_FIFO_ERR_CNT_EN
        check("ovf_cnt",     32'(ovf_cnt),     32'(exp_ovf_cnt));
        check("udf_cnt",     32'(udf_cnt),     32'(exp_udf_cnt));
`endif
    endtask

    task automatic wr(input logic [W-1:0] d); step(0, 1, 0, d); endtask
    task automatic rd();                      step(0, 0, 1, '0); endtask
    task automatic idle();                    step(0, 0, 0, '0); endtask

    task automatic fill_seq(input logic [W-1:0] base);
        for (int i = 0; i < D; i++) wr(base + W'(i));
    endtask

    task automatic drain();
        for (int i = 0; i < D + 1; i++) rd();
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, '0);
        idle();

        // In-order fill and drain of 0x0001..0x0008, then one extra read underflows
        fill_seq(16'h0001);
        drain();

        // Overflow while full: 0xBEEF must never emerge
        fill_seq(16'h0011);
        wr(16'hBEEF);
        drain();

        // Full with simultaneous write+read: head leaves, 0xCAFE enters as 8th word
        fill_seq(16'h0021);
        step(0, 1, 1, 16'hCAFE);
        drain();

        // Empty with simultaneous read+write: only the write lands
        step(0, 1, 1, 16'h1234);
        rd();
        idle();

        // Walk to count 7 and hold there, then interleave across pointer wrap
        for (int i = 0; i < D - 1; i++) wr(16'h0100 + W'(i));
        idle();
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 16'h0200 + W'(i));
            if (i % 3 == 0) rd();
            else wr(16'h0300 + W'(i));
        end
        drain();

        // Reset mid-burst with count 5 and wr_en high
        for (int i = 0; i < 5; i++) wr(16'h0400 + W'(i));
        step(1, 1, 0, 16'hDEAD);
        rd();

        // Long run of overflows and underflows to drive the counters into saturation
        fill_seq(16'h0500);
        for (int i = 0; i < 300; i++) wr(W'($urandom));
        drain();
        for (int i = 0; i < 300; i++) rd();

        // Random traffic, alternating write-heavy and read-heavy phases
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < ((p % 2 == 0) ? 7 : 3)),
                     ($urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 7)), W'($urandom));
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
